// File: rtl/linear_proj_pkg.sv
// Shared types and sizes for the linear-projection loader/drain pair.
// Drain state and matrix ids live here so both sides agree on ordering.
package linear_proj_pkg;

    localparam int OUT_KEYS      = 16;
    localparam int TOTAL_INPUT_W = 8;
    localparam int DRAIN_WORDS   = 3 * 4 * TOTAL_INPUT_W;

    typedef enum logic [1:0] {
        MAT_Q,
        MAT_K,
        MAT_V
    } proj_mat_e;

    typedef enum {
        DRAIN_IDLE,
        DRAIN_STREAM
    } drain_state_e;

endpackage

// File: rtl/linear_proj_drain_idx.sv
// Nested t/head/mat word counter for the projection drain.
// t wraps into head, head wraps into mat; is_last flags the final word.
module linear_proj_drain_idx #(
    parameter int NUM_HEADS     = 4,
    parameter int TOTAL_INPUT_W = linear_proj_pkg::TOTAL_INPUT_W,
    parameter int NUM_MATS      = 3,
    localparam int HW           = $clog2(NUM_HEADS),
    localparam int TW           = $clog2(TOTAL_INPUT_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    output logic [TW-1:0] t,
    output logic [HW-1:0] head,
    output logic [1:0]    mat,
    output logic          is_last
);

    localparam logic [TW-1:0] T_MAX = TW'(TOTAL_INPUT_W - 1);
    localparam logic [HW-1:0] H_MAX = HW'(NUM_HEADS - 1);
    localparam logic [1:0]    M_MAX = 2'(NUM_MATS - 1);

    logic [TW-1:0] t_q, t_d;
    logic [HW-1:0] head_q, head_d;
    logic [1:0]    mat_q, mat_d;
    logic          t_end, h_end, m_end;

    assign t_end = (t_q == T_MAX);
    assign h_end = (head_q == H_MAX);
    assign m_end = (mat_q == M_MAX);

    always_comb begin
        t_d    = t_q;
        head_d = head_q;
        mat_d  = mat_q;
        if (clear) begin
            t_d    = '0;
            head_d = '0;
            mat_d  = '0;
        end else if (step) begin
            if (!t_end) begin
                t_d = t_q + 1'b1;
            end else begin
                t_d = '0;
                if (!h_end) begin
                    head_d = head_q + 1'b1;
                end else begin
                    head_d = '0;
                    mat_d  = m_end ? 2'd0 : mat_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q    <= '0;
            head_q <= '0;
            mat_q  <= '0;
        end else begin
            t_q    <= t_d;
            head_q <= head_d;
            mat_q  <= mat_d;
        end
    end

    assign t       = t_q;
    assign head    = head_q;
    assign mat     = mat_q;
    assign is_last = t_end && h_end && m_end;

endmodule

// File: rtl/linear_proj_out_drain.sv
// Snapshots Q/K/V head arrays and streams them word by word (Q, K, V order).
// Optional LINPROJ_DRAIN_CHECKSUM_EN adds a per-frame XOR checksum output.
module linear_proj_out_drain #(
    parameter int OUT_KEYS      = linear_proj_pkg::OUT_KEYS,
    parameter int TOTAL_INPUT_W = linear_proj_pkg::TOTAL_INPUT_W,
    parameter int NUM_HEADS     = 4,
    parameter int NUM_MATS      = 3,
    localparam int HW           = $clog2(NUM_HEADS),
    localparam int TW           = $clog2(TOTAL_INPUT_W),
    localparam int UW           = 2 + HW + TW,
    localparam int FLAT_W       = NUM_HEADS * TOTAL_INPUT_W * OUT_KEYS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [FLAT_W-1:0]   in_q,
    input  logic [FLAT_W-1:0]   in_k,
    input  logic [FLAT_W-1:0]   in_v,
    output logic [OUT_KEYS-1:0] m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast,
    output logic [UW-1:0]       m_tuser,
`ifdef LINPROJ_DRAIN_CHECKSUM_EN
    output logic [OUT_KEYS-1:0] frame_csum,
    output logic                frame_csum_valid,
`endif
    output logic                busy,
    output logic                overrun
);

    import linear_proj_pkg::*;

    drain_state_e      state_q, state_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic [FLAT_W-1:0] q_snap_q, q_snap_d;
    logic [FLAT_W-1:0] k_snap_q, k_snap_d;
    logic [FLAT_W-1:0] v_snap_q, v_snap_d;

    logic              idx_clear, idx_step, idx_last;
    logic [TW-1:0]     t_idx;
    logic [HW-1:0]     h_idx;
    logic [1:0]        m_idx;
    logic              hs;
    logic [FLAT_W-1:0] mat_sel;
    int unsigned       widx;

    linear_proj_drain_idx #(
        .NUM_HEADS     (NUM_HEADS),
        .TOTAL_INPUT_W (TOTAL_INPUT_W),
        .NUM_MATS      (NUM_MATS)
    ) u_idx (
        .clk     (clk),
        .rst     (rst),
        .clear   (idx_clear),
        .step    (idx_step),
        .t       (t_idx),
        .head    (h_idx),
        .mat     (m_idx),
        .is_last (idx_last)
    );

    assign hs = valid_q && m_tready;

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        q_snap_d  = q_snap_q;
        k_snap_d  = k_snap_q;
        v_snap_d  = v_snap_q;
        idx_clear = 1'b0;
        idx_step  = 1'b0;
        unique case (state_q)
            DRAIN_IDLE: begin
                if (in_valid) begin
                    q_snap_d  = in_q;
                    k_snap_d  = in_k;
                    v_snap_d  = in_v;
                    valid_d   = 1'b1;
                    idx_clear = 1'b1;
                    state_d   = DRAIN_STREAM;
                end
            end
            DRAIN_STREAM: begin
                // Capture only happens from IDLE, even on the last-word cycle.
                if (in_valid) overrun_d = 1'b1;
                if (hs) begin
                    idx_step = 1'b1;
                    if (idx_last) begin
                        valid_d = 1'b0;
                        state_d = DRAIN_IDLE;
                    end
                end
            end
            default: state_d = DRAIN_IDLE;
        endcase
    end

    always_comb begin
        widx = int'(h_idx) * TOTAL_INPUT_W + int'(t_idx);
        case (proj_mat_e'(m_idx))
            MAT_Q:   mat_sel = q_snap_q;
            MAT_K:   mat_sel = k_snap_q;
            default: mat_sel = v_snap_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DRAIN_IDLE;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            q_snap_q  <= '0;
            k_snap_q  <= '0;
            v_snap_q  <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            q_snap_q  <= q_snap_d;
            k_snap_q  <= k_snap_d;
            v_snap_q  <= v_snap_d;
        end
    end

    assign m_tdata  = mat_sel[widx*OUT_KEYS +: OUT_KEYS];
    assign m_tvalid = valid_q;
    assign m_tlast  = valid_q && idx_last;
    assign m_tuser  = {m_idx, h_idx, t_idx};
    assign busy     = (state_q == DRAIN_STREAM);
    assign overrun  = overrun_q;

`ifdef LINPROJ_DRAIN_CHECKSUM_EN
    logic [OUT_KEYS-1:0] csum_q, csum_d;
    logic                csum_v_q, csum_v_d;

    always_comb begin
        csum_d   = csum_q;
        csum_v_d = 1'b0;
        if (state_q == DRAIN_IDLE && in_valid) begin
            csum_d = '0;
        end else if (hs) begin
            csum_d   = csum_q ^ m_tdata;
            csum_v_d = idx_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q   <= '0;
            csum_v_q <= 1'b0;
        end else begin
            csum_q   <= csum_d;
            csum_v_q <= csum_v_d;
        end
    end

    assign frame_csum       = csum_q;
    assign frame_csum_valid = csum_v_q;
`endif

endmodule

// File: tb/tb_linear_proj_out_drain.sv
// Directed bench for linear_proj_out_drain (OUT_KEYS=16, TOTAL_INPUT_W=2).
// Word value encodes {mat,head,t} as 16'hM0HT.
module tb_linear_proj_out_drain;

    localparam int OK  = 16;
    localparam int TIW = 2;
    localparam int NW  = 24;
    localparam int FW  = 4 * TIW * OK;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  user;
        logic        last;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [FW-1:0] in_q, in_k, in_v;
    logic [15:0]   m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic [4:0]    m_tuser;
    logic          busy, overrun;
`ifdef LINPROJ_DRAIN_CHECKSUM_EN
    logic [15:0]   frame_csum;
    logic          frame_csum_valid;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl [NW];
    logic [15:0] exp_xor;

    always #5 clk = ~clk;

    linear_proj_out_drain #(
        .OUT_KEYS      (OK),
        .TOTAL_INPUT_W (TIW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_q     (in_q),
        .in_k     (in_k),
        .in_v     (in_v),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .m_tuser  (m_tuser),
`ifdef LINPROJ_DRAIN_CHECKSUM_EN
        .frame_csum       (frame_csum),
        .frame_csum_valid (frame_csum_valid),
`endif
        .busy     (busy),
        .overrun  (overrun)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_data(input bit alt);
        logic [15:0] w;
        for (int m = 0; m < 3; m++)
            for (int h = 0; h < 4; h++)
                for (int t = 0; t < TIW; t++) begin
                    w = {4'(m), 4'h0, 4'(h), 4'(t)};
                    if (alt) w = w ^ 16'hBEEF;
                    case (m)
                        0: in_q[(h*TIW+t)*OK +: OK] = w;
                        1: in_k[(h*TIW+t)*OK +: OK] = w;
                        default: in_v[(h*TIW+t)*OK +: OK] = w;
                    endcase
                end
    endtask

    task automatic pulse_in(input string tag);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat_valid"}, 32'(m_tvalid), 32'd1);
        check({tag, "_lat_busy"}, 32'(busy), 32'd1);
        check({tag, "_first_word"}, 32'(m_tdata), 32'h0000);
    endtask

    // Drains from the current negedge; inj_at injects a second in_valid
    // with altered data, rst_at asserts reset instead of accepting word k.
    task automatic drain(input string tag, input bit rnd,
                         input int inj_at, input int rst_at);
        int   k = 0;
        int   cyc = 0;
        bit   pv = 0, pr = 0;
        logic [15:0] pd = '0;
        logic [15:0] acc = '0;
        int   early = 0;
        bit   r;
        while (k < NW && cyc < 400) begin
            if (pv && !pr) begin
                check({tag, "_stall_valid"}, 32'(m_tvalid), 32'd1);
                check({tag, "_stall_data"}, 32'(m_tdata), 32'(pd));
            end
`ifdef LINPROJ_DRAIN_CHECKSUM_EN
            if (frame_csum_valid) early++;
`endif
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check({tag, "_rst_valid"}, 32'(m_tvalid), 32'd0);
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_data"}, 32'(m_tdata), 32'd0);
                check({tag, "_rst_overrun"}, 32'(overrun), 32'd0);
                return;
            end
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            m_tready = r;
            if (k == inj_at) begin
                load_data(1'b1);
                in_valid = 1'b1;
            end
            if (m_tvalid && r) begin
                check({tag, "_data"}, 32'(m_tdata), 32'(tbl[k].data));
                check({tag, "_user"}, 32'(m_tuser), 32'(tbl[k].user));
                check({tag, "_last"}, 32'(m_tlast), 32'(tbl[k].last));
                acc = acc ^ m_tdata;
                if (k == inj_at) inj_at = -1;
                k++;
            end
            pv = m_tvalid;
            pr = r;
            pd = m_tdata;
            @(negedge clk);
            if (in_valid) begin
                in_valid = 1'b0;
                load_data(1'b0);
            end
            cyc++;
        end
        m_tready = 1'b0;
        check({tag, "_word_count"}, 32'(k), 32'(NW));
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_valid"}, 32'(m_tvalid), 32'd0);
        check({tag, "_xor_model"}, 32'(acc), 32'(exp_xor));
`ifdef LINPROJ_DRAIN_CHECKSUM_EN
        check({tag, "_csum_early"}, 32'(early), 32'd0);
        check({tag, "_csum_valid"}, 32'(frame_csum_valid), 32'd1);
        check({tag, "_csum"}, 32'(frame_csum), 32'(exp_xor));
        @(negedge clk);
        check({tag, "_csum_pulse"}, 32'(frame_csum_valid), 32'd0);
`endif
    endtask

    initial begin
        for (int m = 0; m < 3; m++)
            for (int h = 0; h < 4; h++)
                for (int t = 0; t < TIW; t++) begin
                    tbl[(m*4+h)*TIW+t].data = {4'(m), 4'h0, 4'(h), 4'(t)};
                    tbl[(m*4+h)*TIW+t].user = {2'(m), 2'(h), 1'(t)};
                    tbl[(m*4+h)*TIW+t].last = (m == 2 && h == 3 && t == 1);
                end
        exp_xor = '0;
        for (int i = 0; i < NW; i++) exp_xor = exp_xor ^ tbl[i].data;
        in_q = '0;
        in_k = '0;
        in_v = '0;
        load_data(1'b0);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(m_tvalid), 32'd0);
        check("rst_last", 32'(m_tlast), 32'd0);
        check("rst_data", 32'(m_tdata), 32'd0);
        check("rst_user", 32'(m_tuser), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
`ifdef LINPROJ_DRAIN_CHECKSUM_EN
        check("rst_csum", 32'(frame_csum), 32'd0);
        check("rst_csum_valid", 32'(frame_csum_valid), 32'd0);
`endif
        rst = 1'b0;

        m_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_valid", 32'(m_tvalid), 32'd0);
        end

        pulse_in("single");
        drain("single", 1'b0, -1, -1);

        pulse_in("bp");
        drain("bp", 1'b1, -1, -1);
        check("bp_overrun", 32'(overrun), 32'd0);

        pulse_in("ovr");
        drain("ovr", 1'b0, 5, -1);
        check("ovr_flag", 32'(overrun), 32'd1);
        pulse_in("third");
        drain("third", 1'b0, -1, -1);
        check("third_sticky", 32'(overrun), 32'd1);

        pulse_in("mid");
        drain("mid", 1'b0, -1, 10);
        pulse_in("restart");
        drain("restart", 1'b0, -1, -1);

        pulse_in("b2b");
        drain("b2b", 1'b0, 23, -1);
        check("b2b_overrun", 32'(overrun), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b_no_capture", 32'(m_tvalid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
